// File: rtl/boothmult_pkg.sv
// Shared types and defaults for the sequential radix-2 Booth multiplier.
package boothmult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BOOTH_N = 8;

endpackage

// File: rtl/booth_seq_adder.sv
// N-bit two's-complement adder; extend is the sign of the exact (N+1)-bit sum.
module booth_seq_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] x0,
  input  logic [N-1:0] x1,
  input  logic         cin,
  output logic [N-1:0] y,
  output logic         extend
);

  logic [N:0] sum;

  // Sign-extending both operands keeps the true sign even when y overflows.
  assign sum    = {x0[N-1], x0} + {x1[N-1], x1} + {{N{1'b0}}, cin};
  assign y      = sum[N-1:0];
  assign extend = sum[N];

endmodule

// File: rtl/booth_seq.sv
// Sequential radix-2 Booth multiplier: N RUN cycles then a one-cycle DONE pulse.
// Optional BOOTHMULT_ZERO_BYPASS_EN: zero operands skip RUN and go straight to DONE.
module booth_seq
  import boothmult_pkg::*;
#(
  parameter int N = BOOTH_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  state_t         state_reg, state_next;
  logic [N-1:0]   a_reg, q_reg, m_reg;
  logic           qm1_reg;
  logic [CW-1:0]  count_reg;
  logic [2*N-1:0] product_reg;

  logic [N-1:0]   x1;
  logic           cin;
  logic [N-1:0]   y;
  logic           extend;
  logic           accept;
  logic           bypass;
  logic           last_step;

  booth_seq_adder #(.N(N)) u_adder (
    .x0     (a_reg),
    .x1     (x1),
    .cin    (cin),
    .y      (y),
    .extend (extend)
  );

  always_comb begin
    x1  = '0;
    cin = 1'b0;
    case ({q_reg[0], qm1_reg})
      2'b01:   x1 = m_reg;
      2'b10: begin
        x1  = ~m_reg;
        cin = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BOOTHMULT_ZERO_BYPASS_EN
  assign bypass = (multiplicand == '0) || (multiplier == '0);
`else
  assign bypass = 1'b0;
`endif

  assign accept    = start && (state_reg != RUN);
  assign last_step = (state_reg == RUN) && (count_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = bypass ? DONE : RUN;
      RUN:  if (count_reg == CW'(1)) state_next = DONE;
      DONE: begin
        if (start) state_next = bypass ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      m_reg       <= '0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= '0;
        q_reg     <= multiplier;
        qm1_reg   <= 1'b0;
        m_reg     <= multiplicand;
        count_reg <= bypass ? '0 : CW'(N);
        if (bypass) product_reg <= '0;
      end else if (state_reg == RUN) begin
        // Arithmetic shift of {A,Q,Qm1}; extend supplies the correct sign on overflow.
        a_reg     <= {extend, y[N-1:1]};
        q_reg     <= {y[0], q_reg[N-1:1]};
        qm1_reg   <= q_reg[0];
        count_reg <= count_reg - CW'(1);
        if (last_step) product_reg <= {extend, y[N-1:1], y[0], q_reg[N-1:1]};
      end
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule
